rename_map: RTL and testbench

Single-issue register-rename stage for the LEGv8 core. It translates architectural source and destination registers of decoded instructions into physical registers. It obtains new destination registers from the physical free list through a one-entry prefetch buffer, and reports the previous mapping so commit can return it to the free list. It keeps a speculative map (used for renaming) and a committed map (used to recover from a flush).

---
 rtl/core_pkg.sv | 17 +
 rtl/rename_prefetch.sv | 62 ++++++
 rtl/rename_map.sv | 121 ++++++++++++
 tb/tb_rename_map.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared core types: register counts, physical tag type, prefetch states
package core_pkg;
    localparam int ARCH_REGS = 32;
    localparam int PREGS     = 64;
    localparam int PTAG_W    = 6;

    typedef logic [PTAG_W-1:0] phys_tag_t;
    typedef logic [4:0]        arch_reg_t;

    localparam arch_reg_t XZR = 5'd31;

    typedef enum logic [1:0] {
        PF_EMPTY,
        PF_WAIT,
        PF_FULL
    } pf_state_e;
endpackage

// File: rtl/rename_prefetch.sv
// rtl/rename_prefetch.sv - one-entry spare physical register prefetched from the free list
module rename_prefetch
    import core_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    output logic      alloc_en,
    input  phys_tag_t alloc_phys,
    input  logic      alloc_valid,
    input  logic      consume,
    output logic      spare_valid,
    output phys_tag_t spare
);
    pf_state_e r_state;
    pf_state_e w_state_nxt;
    phys_tag_t r_spare;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= PF_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            PF_EMPTY: w_state_nxt = PF_WAIT;
            PF_WAIT:  w_state_nxt = alloc_valid ? PF_FULL : PF_EMPTY;
            PF_FULL:  w_state_nxt = consume ? PF_WAIT : PF_FULL;
            default:  w_state_nxt = PF_EMPTY;
        endcase
    end

    // alloc_en is held low during reset so no grant is requested before the FSM starts
    always_comb begin
        alloc_en    = 1'b0;
        spare_valid = 1'b0;
        case (r_state)
            PF_EMPTY: alloc_en = !reset;
            PF_FULL: begin
                alloc_en    = consume;
                spare_valid = 1'b1;
            end
            default: begin
                alloc_en    = 1'b0;
                spare_valid = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_spare <= '0;
        end else if (r_state == PF_WAIT && alloc_valid) begin
            r_spare <= alloc_phys;
        end
    end

    assign spare = r_spare;
endmodule

// File: rtl/rename_map.sv
// rtl/rename_map.sv - single-issue rename stage with speculative and committed maps
module rename_map
    import core_pkg::*;
#(
    parameter int ARCH_REGS = core_pkg::ARCH_REGS,
    parameter int PHYS_REGS = core_pkg::PREGS
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [4:0]                   in_rs1,
    input  logic [4:0]                   in_rs2,
    input  logic [4:0]                   in_rd,
    input  logic                         in_rd_we,
    output logic                         alloc_en,
    input  logic [$clog2(PHYS_REGS)-1:0] alloc_phys,
    input  logic                         alloc_valid,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(PHYS_REGS)-1:0] out_prs1,
    output logic [$clog2(PHYS_REGS)-1:0] out_prs2,
    output logic [$clog2(PHYS_REGS)-1:0] out_prd,
    output logic [$clog2(PHYS_REGS)-1:0] out_old_prd,
    output logic                         out_rd_we,
    input  logic                         commit_en,
    input  logic [4:0]                   commit_rd,
    input  logic [$clog2(PHYS_REGS)-1:0] commit_prd,
    input  logic                         flush
);
    localparam int TAG_W = $clog2(PHYS_REGS);

    logic [TAG_W-1:0] r_spec_map   [ARCH_REGS];
    logic [TAG_W-1:0] r_commit_map [ARCH_REGS];

    logic             w_eff_we;
    logic             w_accept;
    logic             w_consume;
    logic             w_commit_we;
    logic             w_spare_valid;
    phys_tag_t        w_spare;

    logic             r_out_valid;
    logic [TAG_W-1:0] r_out_prs1;
    logic [TAG_W-1:0] r_out_prs2;
    logic [TAG_W-1:0] r_out_prd;
    logic [TAG_W-1:0] r_out_old_prd;
    logic             r_out_rd_we;

    assign w_eff_we    = in_rd_we && (in_rd != XZR);
    assign in_ready    = !flush && (!r_out_valid || out_ready) && (!w_eff_we || w_spare_valid);
    assign w_accept    = in_valid && in_ready;
    assign w_consume   = w_accept && w_eff_we;
    assign w_commit_we = commit_en && (commit_rd != XZR);

    rename_prefetch u_prefetch (
        .clk         (clk),
        .reset       (reset),
        .alloc_en    (alloc_en),
        .alloc_phys  (alloc_phys),
        .alloc_valid (alloc_valid),
        .consume     (w_consume),
        .spare_valid (w_spare_valid),
        .spare       (w_spare)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                r_commit_map[i] <= TAG_W'(i);
            end
        end else if (w_commit_we) begin
            r_commit_map[commit_rd] <= commit_prd;
        end
    end

    // Flush restores from the committed map including a commit landing in the same cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                r_spec_map[i] <= TAG_W'(i);
            end
        end else if (flush) begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                r_spec_map[i] <= (w_commit_we && commit_rd == 5'(i)) ? commit_prd
                                                                     : r_commit_map[i];
            end
        end else if (w_consume) begin
            r_spec_map[in_rd] <= w_spare;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid   <= 1'b0;
            r_out_prs1    <= '0;
            r_out_prs2    <= '0;
            r_out_prd     <= '0;
            r_out_old_prd <= '0;
            r_out_rd_we   <= 1'b0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_out_valid   <= 1'b1;
            r_out_prs1    <= r_spec_map[in_rs1];
            r_out_prs2    <= r_spec_map[in_rs2];
            r_out_rd_we   <= w_eff_we;
            r_out_prd     <= w_eff_we ? w_spare : '0;
            r_out_old_prd <= w_eff_we ? r_spec_map[in_rd] : '0;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid   = r_out_valid;
    assign out_prs1    = r_out_prs1;
    assign out_prs2    = r_out_prs2;
    assign out_prd     = r_out_prd;
    assign out_old_prd = r_out_old_prd;
    assign out_rd_we   = r_out_rd_we;
endmodule

// File: tb/tb_rename_map.sv
// tb/tb_rename_map.sv - directed self-checking bench for rename_map
module tb_rename_map;
    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [4:0] in_rs1;
    logic [4:0] in_rs2;
    logic [4:0] in_rd;
    logic       in_rd_we;
    logic       alloc_en;
    logic [5:0] alloc_phys;
    logic       alloc_valid;
    logic       out_valid;
    logic       out_ready;
    logic [5:0] out_prs1;
    logic [5:0] out_prs2;
    logic [5:0] out_prd;
    logic [5:0] out_old_prd;
    logic       out_rd_we;
    logic       commit_en;
    logic [4:0] commit_rd;
    logic [5:0] commit_prd;
    logic       flush;

    int n_cmp;
    int n_err;
    int n_alloc;
    int alloc_snap;

    rename_map dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_rs1      (in_rs1),
        .in_rs2      (in_rs2),
        .in_rd       (in_rd),
        .in_rd_we    (in_rd_we),
        .alloc_en    (alloc_en),
        .alloc_phys  (alloc_phys),
        .alloc_valid (alloc_valid),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_prs1    (out_prs1),
        .out_prs2    (out_prs2),
        .out_prd     (out_prd),
        .out_old_prd (out_old_prd),
        .out_rd_we   (out_rd_we),
        .commit_en   (commit_en),
        .commit_rd   (commit_rd),
        .commit_prd  (commit_prd),
        .flush       (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one cycle; alloc_en is sampled at the negedge when inputs are settled
    task automatic tick();
        @(negedge clk);
        if (alloc_en === 1'b1) n_alloc++;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic we);
        in_valid = v;
        in_rs1   = rs1;
        in_rs2   = rs2;
        in_rd    = rd;
        in_rd_we = we;
        #1;
    endtask

    task automatic check_out(input string tag, input logic [5:0] p1, input logic [5:0] p2,
                             input logic [5:0] pd, input logic [5:0] old, input logic we);
        check({tag, ".valid"}, 32'(out_valid), 32'd1);
        check({tag, ".prs1"}, 32'(out_prs1), 32'(p1));
        check({tag, ".prs2"}, 32'(out_prs2), 32'(p2));
        check({tag, ".prd"}, 32'(out_prd), 32'(pd));
        check({tag, ".old_prd"}, 32'(out_old_prd), 32'(old));
        check({tag, ".rd_we"}, 32'(out_rd_we), 32'(we));
    endtask

    initial begin
        n_cmp = 0; n_err = 0; n_alloc = 0; alloc_snap = 0;
        reset = 1'b1;
        in_valid = 0; in_rs1 = 0; in_rs2 = 0; in_rd = 0; in_rd_we = 0;
        alloc_phys = 6'd32; alloc_valid = 1'b1;
        out_ready = 1'b1;
        commit_en = 0; commit_rd = 0; commit_prd = 0; flush = 0;

        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst.alloc_en", 32'(alloc_en), 32'd0);
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.out_prd", 32'(out_prd), 32'd0);
        check("rst.out_prs1", 32'(out_prs1), 32'd0);

        // cycle 0: PF_EMPTY
        reset = 1'b0;
        drive(1, 5'd1, 5'd2, 5'd3, 1);
        check("c0.alloc_en", 32'(alloc_en), 32'd1);
        check("c0.in_ready", 32'(in_ready), 32'd0);
        tick();
        check("c1.alloc_en", 32'(alloc_en), 32'd0);
        check("c1.in_ready", 32'(in_ready), 32'd0);
        tick();
        check("c2.in_ready", 32'(in_ready), 32'd1);
        check("c2.alloc_en", 32'(alloc_en), 32'd1);
        alloc_phys = 6'd33;
        tick();
        check_out("i1", 6'd1, 6'd2, 6'd32, 6'd3, 1'b1);

        // dependent instruction waits for refill
        drive(1, 5'd3, 5'd0, 5'd3, 1);
        check("c3.in_ready", 32'(in_ready), 32'd0);
        tick();
        check("c4.out_valid", 32'(out_valid), 32'd0);
        check("c4.in_ready", 32'(in_ready), 32'd1);
        alloc_phys = 6'd34;
        tick();
        check_out("i2", 6'd32, 6'd0, 6'd33, 6'd32, 1'b1);

        // XZR write and no-write back to back, no allocation
        alloc_snap = n_alloc;
        drive(1, 5'd31, 5'd5, 5'd31, 1);
        check("xzr.in_ready", 32'(in_ready), 32'd1);
        tick();
        check_out("xzr", 6'd31, 6'd5, 6'd0, 6'd0, 1'b0);
        drive(1, 5'd3, 5'd31, 5'd7, 0);
        check("nowe.in_ready", 32'(in_ready), 32'd1);
        tick();
        check_out("nowe", 6'd33, 6'd31, 6'd0, 6'd0, 1'b0);
        check("xzr.no_alloc", 32'(n_alloc - alloc_snap), 32'd0);
        check("alloc_total", 32'(n_alloc), 32'd3);

        // backpressure for three cycles
        out_ready = 1'b0;
        drive(1, 5'd1, 5'd2, 5'd8, 0);
        for (int k = 0; k < 3; k++) begin
            check("bp.in_ready", 32'(in_ready), 32'd0);
            check_out("bp", 6'd33, 6'd31, 6'd0, 6'd0, 1'b0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("bp.release_ready", 32'(in_ready), 32'd1);
        tick();
        check_out("bp.new", 6'd1, 6'd2, 6'd0, 6'd0, 1'b0);
        drive(0, 5'd0, 5'd0, 5'd0, 0);
        tick();
        check("drain.out_valid", 32'(out_valid), 32'd0);

        // free list empty: spare 34 consumed, refill fails twice, then grant 40
        alloc_valid = 1'b0;
        drive(1, 5'd0, 5'd3, 5'd9, 1);
        check("fe.in_ready0", 32'(in_ready), 32'd1);
        tick();
        check_out("fe.i", 6'd0, 6'd33, 6'd34, 6'd9, 1'b1);
        drive(1, 5'd0, 5'd0, 5'd10, 1);
        check("fe.wait_ready", 32'(in_ready), 32'd0);
        tick();
        check("fe.retry1", 32'(alloc_en), 32'd1);
        check("fe.stall1", 32'(in_ready), 32'd0);
        tick();
        check("fe.wait2", 32'(alloc_en), 32'd0);
        tick();
        check("fe.retry2", 32'(alloc_en), 32'd1);
        alloc_valid = 1'b1;
        alloc_phys = 6'd40;
        tick();
        check("fe.stall3", 32'(in_ready), 32'd0);
        tick();
        check("fe.ready", 32'(in_ready), 32'd1);
        alloc_phys = 6'd32;
        tick();
        check_out("fe.o", 6'd0, 6'd0, 6'd40, 6'd10, 1'b1);

        // flush with simultaneous commit
        drive(1, 5'd5, 5'd0, 5'd5, 1);
        tick();
        check("fl.ready5", 32'(in_ready), 32'd1);
        alloc_phys = 6'd33;
        tick();
        check_out("fl.r5", 6'd5, 6'd0, 6'd32, 6'd5, 1'b1);
        drive(1, 5'd6, 5'd0, 5'd6, 1);
        tick();
        check("fl.ready6", 32'(in_ready), 32'd1);
        alloc_phys = 6'd41;
        tick();
        check_out("fl.r6", 6'd6, 6'd0, 6'd33, 6'd6, 1'b1);
        flush = 1'b1;
        commit_en = 1'b1; commit_rd = 5'd5; commit_prd = 6'd32;
        drive(1, 5'd0, 5'd0, 5'd0, 0);
        check("fl.in_ready", 32'(in_ready), 32'd0);
        tick();
        flush = 1'b0; commit_en = 1'b0;
        check("fl.out_valid", 32'(out_valid), 32'd0);
        drive(1, 5'd5, 5'd6, 5'd0, 0);
        tick();
        check_out("fl.read", 6'd32, 6'd6, 6'd0, 6'd0, 1'b0);
        drive(1, 5'd31, 5'd7, 5'd7, 1);
        check("fl.spare_held", 32'(in_ready), 32'd1);
        tick();
        check_out("fl.spare", 6'd31, 6'd7, 6'd41, 6'd7, 1'b1);

        // mid-operation reset takes effect without a clock edge
        reset = 1'b1;
        #1;
        check("mr.out_valid", 32'(out_valid), 32'd0);
        check("mr.alloc_en", 32'(alloc_en), 32'd0);
        tick();
        reset = 1'b0;
        drive(1, 5'd5, 5'd3, 5'd0, 0);
        check("mr.alloc_en0", 32'(alloc_en), 32'd1);
        tick();
        check_out("mr.map", 6'd5, 6'd3, 6'd0, 6'd0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
